// File: rtl/atan2_quadrant.sv
// Folds (x,y) into the first quadrant for an external CORDIC core and unfolds its phase to full circle.
// Latency: dout_valid one cycle after core_dout_valid (3 cycles after accept for the bypassed origin); din_ready drops only when the input FIFO is full.
module atan2_quadrant #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DIN_WIDTH-1:0] din_x,
  input  logic signed [DIN_WIDTH-1:0] din_y,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [DIN_WIDTH-1:0]        core_x,
  output logic [DIN_WIDTH-1:0]        core_y,
  output logic                        core_valid,
  input  logic                        core_ready,
  input  logic [DOUT_WIDTH-1:0]       core_dout,
  input  logic                        core_dout_valid,
  output logic [DOUT_WIDTH-1:0]       dout,
  output logic                        dout_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DOUT_WIDTH-1:0] HALF_TURN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic [DOUT_WIDTH-1:0] PHASE_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                 state_q, state_d;
  logic [2*DIN_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [2*DIN_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DIN_WIDTH-1:0]   ax_q, ax_d, ay_q, ay_d;
  logic                   sx_q, sx_d, sy_q, sy_d, byp_q, byp_d;
  logic [DOUT_WIDTH-1:0]  dout_q, dout_d, phase;
  logic                   dout_valid_q, dout_valid_d;
  logic                   fifo_empty, fifo_full, push, pop;
  logic signed [DIN_WIDTH-1:0] head_x, head_y;

  function automatic logic [DIN_WIDTH-1:0] fold(input logic signed [DIN_WIDTH-1:0] v);
    logic signed [DIN_WIDTH-1:0] neg;
    neg = -v;
    // -2^(N-1) has no positive twin; clamp it to the largest magnitude
    if (v == {1'b1, {(DIN_WIDTH-1){1'b0}}}) return {1'b0, {(DIN_WIDTH-1){1'b1}}};
    else if (v[DIN_WIDTH-1])                return neg;
    else                                    return v;
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign din_ready  = !fifo_full;
  assign push       = din_valid && !fifo_full;
  assign {head_x, head_y} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {din_x, din_y};
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_comb begin
    phase = core_dout;
    case ({sx_q, sy_q})
      2'b00:   phase = core_dout;
      2'b10:   phase = (core_dout == '0) ? PHASE_MAX : HALF_TURN - core_dout;
      2'b11:   phase = core_dout - HALF_TURN;
      default: phase = -core_dout;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ax_d         = ax_q;
    ay_d         = ay_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    byp_d        = byp_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    core_valid   = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          ax_d    = fold(head_x);
          ay_d    = fold(head_y);
          sx_d    = head_x[DIN_WIDTH-1];
          sy_d    = head_y[DIN_WIDTH-1];
          byp_d   = (head_x == '0) && (head_y == '0);
          state_d = byp_d ? OUT : ISSUE;
        end
      end
      ISSUE: begin
        if (core_ready) begin
          core_valid = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (core_dout_valid) begin
          dout_d       = phase;
          dout_valid_d = 1'b1;
          state_d      = OUT;
        end
      end
      OUT: begin
        // core results were already emitted on the WAIT exit; only the origin emits here
        if (byp_q) begin
          dout_d       = '0;
          dout_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ax_q         <= '0;
      ay_q         <= '0;
      sx_q         <= 1'b0;
      sy_q         <= 1'b0;
      byp_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      byp_q        <= byp_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      mem_q        <= mem_d;
    end
  end

  assign core_x     = ax_q;
  assign core_y     = ay_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_atan2_quadrant.sv
// Bench for atan2_quadrant: directed quadrant/bypass/stall/reset steps plus a randomized run against a quadrant-rule model.
module tb_atan2_quadrant;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic signed [15:0] din_x = '0, din_y = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic [15:0]        core_x, core_y;
  logic               core_valid;
  logic               core_ready;
  logic [15:0]        core_dout = '0;
  logic               core_dout_valid = 1'b0;
  logic [15:0]        dout;
  logic               dout_valid;

  atan2_quadrant dut (
    .clk(clk), .rst(rst),
    .din_x(din_x), .din_y(din_y), .din_valid(din_valid), .din_ready(din_ready),
    .core_x(core_x), .core_y(core_y), .core_valid(core_valid), .core_ready(core_ready),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .dout(dout), .dout_valid(dout_valid)
  );

  int vectors = 0, miscompares = 0;
  typedef struct {int x; int y;} samp_t;
  samp_t sq[$];
  samp_t mon_s;
  int acc_cnt = 0, hs_cnt = 0, out_cnt = 0;
  int cur_z = 0, job_z = 0, z_fix = -1, lat_fix = 0, lat_cnt = 0;
  logic core_en = 1'b1, core_busy = 1'b0, hs_pending = 1'b0;

  assign core_ready = core_en & ~core_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fold_ref(input int v);
    int a;
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    return a;
  endfunction

  // phase/pi in Q1.15 from the signs of the original operands and the first-quadrant z
  function automatic logic [15:0] phase_ref(input int x, input int y, input int z);
    int r;
    if (x == 0 && y == 0)     r = 0;
    else if (x >= 0 && y >= 0) r = z;
    else if (x < 0 && y >= 0)  r = (z == 0) ? 32767 : 32768 - z;
    else if (x < 0)            r = z - 32768;
    else                       r = -z;
    return r[15:0];
  endfunction

  always @(posedge clk) begin
    if (rst) sq.delete();
    else begin
      if (din_valid && din_ready) begin
        sq.push_back('{int'(din_x), int'(din_y)});
        acc_cnt++;
      end
      if (core_valid && core_ready) begin
        hs_cnt++;
        hs_pending = 1'b1;
        job_z = (z_fix >= 0) ? z_fix : int'($urandom_range(0, 16384));
        cur_z = job_z;
        if (sq.size() == 0) check("core_valid_unexpected", core_valid, 0);
        else begin
          check("core_valid_bypass", core_valid, (sq[0].x != 0 || sq[0].y != 0));
          check("core_x", core_x, fold_ref(sq[0].x));
          check("core_y", core_y, fold_ref(sq[0].y));
        end
      end
    end
  end

  // CORDIC stand-in: busy after a handshake, answers after lat cycles
  always @(negedge clk) begin
    core_dout_valid = 1'b0;
    if (hs_pending) begin
      hs_pending = 1'b0;
      core_busy  = 1'b1;
      lat_cnt    = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
    end else if (core_busy) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        core_dout       = job_z[15:0];
        core_dout_valid = 1'b1;
        core_busy       = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (core_valid && !core_ready) check("core_valid_without_ready", core_ready, 1);
    if (dout_valid) begin
      if (sq.size() == 0) check("dout_valid_unexpected", dout_valid, 0);
      else begin
        mon_s = sq.pop_front();
        check("dout", dout, phase_ref(mon_s.x, mon_s.y, cur_z));
        out_cnt++;
      end
    end
  end

  task automatic send(input int x, input int y);
    bit r;
    r = 1'b0;
    din_valid = 1'b1;
    din_x = x[15:0];
    din_y = y[15:0];
    for (int i = 0; i < 200 && !r; i++) begin
      #1;
      r = din_ready;
      @(posedge clk);
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("send_accept", r, 1);
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && sq.size() != 0; i++) @(negedge clk);
    check("drain", sq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int h0, o0, a0, k, sel, rx, ry;
    int px[6];
    int py[6];
    bit r;
    px = '{100, -200, 300, -400, 500, -600};
    py = '{-7, 11, 13, -17, -19, 23};

    // reset wins over a simultaneous din_valid
    rst = 1'b1; din_valid = 1'b1; din_x = 16'sd123; din_y = 16'sd45;
    repeat (3) @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    #1;
    check("rst_din_ready", din_ready, 1);
    check("rst_core_valid", core_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_core_x", core_x, 0);
    check("rst_core_y", core_y, 0);
    repeat (6) @(negedge clk);
    check("rst_priority_no_accept", acc_cnt, 0);
    check("rst_priority_no_output", out_cnt, 0);

    // first quadrant, fixed core answer
    z_fix = 'h2000;
    h0 = hs_cnt; o0 = out_cnt;
    send(1000, 1000);
    wait_drain(100);
    check("q1_core_pulses", hs_cnt - h0, 1);
    check("q1_results", out_cnt - o0, 1);
    repeat (3) @(negedge clk);
    #1 check("q1_dout_hold", dout, 16'h2000);

    send(-1000, 1000);  wait_drain(100); #1 check("q2_dout", dout, 16'h6000);
    send(-1000, -1000); wait_drain(100); #1 check("q3_dout", dout, 16'hA000);
    send(1000, -1000);  wait_drain(100); #1 check("q4_dout", dout, 16'hE000);

    // origin bypasses the core; result in the third cycle after the accepting edge
    @(negedge clk);
    h0 = hs_cnt;
    din_valid = 1'b1; din_x = '0; din_y = '0;
    #1 check("bypass_ready", din_ready, 1);
    @(posedge clk);
    @(negedge clk); din_valid = 1'b0;
    #1 check("bypass_lat_c1", dout_valid, 0);
    @(negedge clk); #1 check("bypass_lat_c2", dout_valid, 0);
    @(negedge clk); #1 check("bypass_lat_c3", dout_valid, 1);
    check("bypass_dout", dout, 0);
    check("bypass_no_core", hs_cnt - h0, 0);
    wait_drain(20);

    // most negative x saturates; z=0 in quadrant 2 clamps to just under +1
    z_fix = 0;
    send(-32768, 0);
    wait_drain(100);
    #1 check("neg_sat_dout", dout, 16'h7FFF);

    // stalled core: FIFO plus working registers hold five samples
    z_fix = -1;
    @(negedge clk);
    core_en = 1'b0; a0 = acc_cnt; o0 = out_cnt; k = 0;
    for (int c = 0; c < 12; c++) begin
      din_valid = 1'b1;
      if (k < 6) begin din_x = px[k][15:0]; din_y = py[k][15:0]; end
      #1 r = din_ready;
      @(posedge clk);
      @(negedge clk);
      if (r) k++;
    end
    #1;
    check("stall_accepted", acc_cnt - a0, 5);
    check("stall_din_ready", din_ready, 0);
    check("stall_no_output", out_cnt - o0, 0);
    core_en = 1'b1;
    for (int c = 0; c < 200 && k < 6; c++) begin
      if (k < 6) begin din_x = px[k][15:0]; din_y = py[k][15:0]; end
      #1 r = din_ready;
      @(posedge clk);
      @(negedge clk);
      if (r) k++;
    end
    din_valid = 1'b0;
    check("stall_sixth_accepted", k, 6);
    wait_drain(300);
    check("stall_results", out_cnt - o0, 6);

    // core_ready low while a sample waits in ISSUE
    core_en = 1'b0; h0 = hs_cnt;
    send(500, -300);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1 check("issue_hold_cv", core_valid, 0);
    end
    @(negedge clk);
    core_en = 1'b1;
    #1 check("issue_cv_on_ready", core_valid, 1);
    @(negedge clk);
    #1 check("issue_cv_single", core_valid, 0);
    check("issue_pulses", hs_cnt - h0, 1);
    wait_drain(100);

    // reset while waiting on the core; the late answer must be dropped
    lat_fix = 6; h0 = hs_cnt; o0 = out_cnt;
    send(700, 200);
    for (int c = 0; c < 50 && hs_cnt == h0; c++) @(negedge clk);
    check("abandon_issued", hs_cnt - h0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("abandon_no_output", out_cnt - o0, 0);
    check("abandon_dout", dout, 0);
    lat_fix = 0; o0 = out_cnt;
    send(-5, 7);
    wait_drain(100);
    check("abandon_next_ok", out_cnt - o0, 1);

    // randomized samples with corner values mixed in
    o0 = out_cnt;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      rx = int'($urandom_range(0, 65535)) - 32768;
      ry = int'($urandom_range(0, 65535)) - 32768;
      case (sel)
        0: begin rx = 0; ry = 0; end
        1: rx = -32768;
        2: ry = -32768;
        3: rx = 0;
        4: ry = 0;
        default: ;
      endcase
      send(rx, ry);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(2000);
    check("random_results", out_cnt - o0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
